// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: instruction constants, word size
// and the next-PC source encoding used by the fetch stage.
package mips_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_HOLD,
        PC_BRANCH,
        PC_JUMP
    } pc_sel_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: a flush inserts a bubble and beats a stall,
// and a stall holds the current contents.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    input  logic        valid_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instr    <= NOP;
            pc_plus4 <= 32'h0000_0000;
            valid    <= 1'b0;
        end else if (!stall) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= valid_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, picks the next PC from stall/branch/jump inputs,
// checks fetch addresses and feeds the IF/ID register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = 64,
    parameter int          COUNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_f,
    input  logic               stall_d,
    input  logic               flush_d,
    input  logic               pc_src_d,
    input  logic [31:0]        pc_branch_d,
    input  logic               jump_d,
    input  logic [31:0]        pc_jump_d,
    input  logic [31:0]        imem_rd,
    output logic [31:0]        pc_f,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_plus4_d,
    output logic               valid_d,
    output logic               addr_err,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [31:0]        IMEM_BYTES = 32'(IMEM_WORDS * WORD_BYTES);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

    pc_sel_e     pc_sel;
    logic [31:0] pc_plus4_f;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        out_of_range;
    logic        capture;

    assign pc_plus4_f   = pc_f + 32'd4;
    assign out_of_range = (pc_f >= IMEM_BYTES);
    assign capture      = !flush_d && !stall_d;

    // stall_f must beat both redirects: a held PC drops the redirect entirely.
    always_comb begin
        pc_sel = PC_SEQ;
        if (stall_f)       pc_sel = PC_HOLD;
        else if (pc_src_d) pc_sel = PC_BRANCH;
        else if (jump_d)   pc_sel = PC_JUMP;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_pc    = pc_plus4_f;
        misaligned = 1'b0;
        unique case (pc_sel)
            PC_HOLD:   next_pc = pc_f;
            PC_BRANCH: begin
                next_pc    = {pc_branch_d[31:2], 2'b00};
                misaligned = |pc_branch_d[1:0];
            end
            PC_JUMP: begin
                next_pc    = {pc_jump_d[31:2], 2'b00};
                misaligned = |pc_jump_d[1:0];
            end
            PC_SEQ:    next_pc = pc_plus4_f;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f        <= RESET_PC;
            addr_err    <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc_f <= next_pc;
            if (misaligned || (capture && out_of_range))
                addr_err <= 1'b1;
            if (capture && !out_of_range)
                fetch_count <= fetch_count + COUNT_ONE;
        end
    end

    // An out-of-range fetch is turned into a bubble before it reaches IF/ID.
    if_id_reg u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush_d),
        .stall       (stall_d),
        .instr_in    (out_of_range ? NOP : imem_rd),
        .pc_plus4_in (pc_plus4_f),
        .valid_in    (!out_of_range),
        .instr       (instr_d),
        .pc_plus4    (pc_plus4_d),
        .valid       (valid_d)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues the hand-computed state
// expected after each edge, and a monitor compares it just after that edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall_f, stall_d, flush_d, pc_src_d, jump_d;
    logic [31:0] pc_branch_d, pc_jump_d, imem_rd;
    logic [31:0] pc_f, instr_d, pc_plus4_d, fetch_count;
    logic        valid_d, addr_err;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        pc4_dc;
        logic        valid;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    bit   driver_done = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory stand-in: a recognisable word derived from the address.
    function automatic logic [31:0] w(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rd = w(pc_f);

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_d    (pc_src_d),
        .pc_branch_d (pc_branch_d),
        .jump_d      (jump_d),
        .pc_jump_d   (pc_jump_d),
        .imem_rd     (imem_rd),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .addr_err    (addr_err),
        .fetch_count (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_d = 1'b0; jump_d = 1'b0; pc_branch_d = '0; pc_jump_d = '0;
    endtask

    // Queue the expected post-edge state, then advance one clock.
    task automatic cyc(input string name, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic valid, input logic err,
                       input logic [31:0] cnt, input logic pc4_dc = 1'b0);
        exp_t e;
        e.name = name; e.pc = pc; e.instr = instr; e.pc4 = pc4; e.pc4_dc = pc4_dc;
        e.valid = valid; e.err = err; e.cnt = cnt;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    // Monitor: compare against the scoreboard shortly after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".pc_f"},        pc_f,               e.pc);
                check({e.name, ".instr_d"},     instr_d,            e.instr);
                if (!e.pc4_dc)
                    check({e.name, ".pc_plus4_d"}, pc_plus4_d,      e.pc4);
                check({e.name, ".valid_d"},     {31'd0, valid_d},   {31'd0, e.valid});
                check({e.name, ".addr_err"},    {31'd0, addr_err},  {31'd0, e.err});
                check({e.name, ".fetch_count"}, fetch_count,        e.cnt);
            end
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        cyc("reset",  32'h0, 32'h0,    32'h0, 1'b0, 1'b0, 0);
        cyc("run1",   32'h4, w(32'h0), 32'h4, 1'b1, 1'b0, 1);
        cyc("run2",   32'h8, w(32'h4), 32'h8, 1'b1, 1'b0, 2);
        cyc("run3",   32'hC, w(32'h8), 32'hC, 1'b1, 1'b0, 3);

        // Stall at pc_f = 8
        reset = 1'b1;
        cyc("reset2", 32'h0, 32'h0,    32'h0, 1'b0, 1'b0, 0);
        cyc("pre1",   32'h4, w(32'h0), 32'h4, 1'b1, 1'b0, 1);
        cyc("pre2",   32'h8, w(32'h4), 32'h8, 1'b1, 1'b0, 2);
        stall_f = 1'b1; stall_d = 1'b1;
        cyc("stall1", 32'h8, w(32'h4), 32'h8, 1'b1, 1'b0, 2);
        stall_f = 1'b1; stall_d = 1'b1;
        cyc("stall2", 32'h8, w(32'h4), 32'h8, 1'b1, 1'b0, 2);
        cyc("resume1", 32'hC,  w(32'h8), 32'hC,  1'b1, 1'b0, 3);
        cyc("resume2", 32'h10, w(32'hC), 32'h10, 1'b1, 1'b0, 4);

        // Branch with flush, then branch+jump together (branch wins)
        pc_src_d = 1'b1; pc_branch_d = 32'h20; flush_d = 1'b1;
        cyc("branch",  32'h20, 32'h0,     32'h0,  1'b0, 1'b0, 4);
        cyc("br_tgt",  32'h24, w(32'h20), 32'h24, 1'b1, 1'b0, 5);
        pc_src_d = 1'b1; pc_branch_d = 32'h20; jump_d = 1'b1; pc_jump_d = 32'h40; flush_d = 1'b1;
        cyc("br_jmp",  32'h20, 32'h0,     32'h0,  1'b0, 1'b0, 5);
        cyc("bj_tgt",  32'h24, w(32'h20), 32'h24, 1'b1, 1'b0, 6);

        // Misaligned jump target: aligned down, sticky error
        jump_d = 1'b1; pc_jump_d = 32'h1E; flush_d = 1'b1;
        cyc("mis_jmp", 32'h1C, 32'h0,     32'h0,  1'b0, 1'b1, 6);
        cyc("mis_f1",  32'h20, w(32'h1C), 32'h20, 1'b1, 1'b1, 7);
        cyc("mis_f2",  32'h24, w(32'h20), 32'h24, 1'b1, 1'b1, 8);

        // Flush and stall together: flush wins; then a stall holds the bubble
        flush_d = 1'b1; stall_d = 1'b1;
        cyc("fl_st",   32'h28, 32'h0,     32'h0,  1'b0, 1'b1, 8);
        stall_d = 1'b1;
        cyc("st_bub",  32'h2C, 32'h0,     32'h0,  1'b0, 1'b1, 8);
        cyc("post_st", 32'h30, w(32'h2C), 32'h30, 1'b1, 1'b1, 9);

        // Reset beats a concurrent stall and redirect
        reset = 1'b1; stall_f = 1'b1; pc_src_d = 1'b1; pc_branch_d = 32'h20;
        cyc("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0);

        // Walk to the top of instruction memory and past it
        jump_d = 1'b1; pc_jump_d = 32'hF8; flush_d = 1'b1;
        cyc("to_f8",   32'hF8,  32'h0,     32'h0,   1'b0, 1'b0, 0);
        cyc("at_fc",   32'hFC,  w(32'hF8), 32'hFC,  1'b1, 1'b0, 1);
        cyc("at_100",  32'h100, w(32'hFC), 32'h100, 1'b1, 1'b0, 2);
        cyc("oor",     32'h104, 32'h0,     32'h0,   1'b0, 1'b1, 2, 1'b1);

        // PC+4 wraps to zero; zero is back in range
        jump_d = 1'b1; pc_jump_d = 32'hFFFF_FFFC; flush_d = 1'b1;
        cyc("to_top",  32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b1, 2);
        cyc("wrap",    32'h0,   32'h0,    32'h0, 1'b0, 1'b1, 2, 1'b1);
        cyc("wrap_f",  32'h4,   w(32'h0), 32'h4, 1'b1, 1'b1, 3);

        @(posedge clk);
        #2;
        driver_done = 1'b1;
    end

    initial begin
        fork
            wait (driver_done);
            #100000;
        join_any
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        if (!driver_done) check("driver_finished", 32'd0, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
